// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, funct3 encodings and
// the access-legality rule used at request acceptance.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD_RSP = 2'd1,
        S_RMW_WR   = 2'd2,
        S_ERR_RSP  = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads; any other funct3 is illegal.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic e;
        case (f3)
            F3_B:    e = 1'b0;
            F3_H:    e = off[0];
            F3_W:    e = |off;
            F3_BU:   e = we;
            F3_HU:   e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Selects the addressed byte/halfword lane of a RAM word and extends it to
// 32 bits according to the load funct3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = word >> {lane, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one access at a time against a word RAM with a
// combinational read port; sub-word stores use a read-modify-write cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    lsu_state_e               state_q, state_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]    merge_q, merge_d;
    logic [ADDRESS_WIDTH-1:0] index_q, index_d;

    logic [ADDRESS_WIDTH-1:0] req_index;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    merge_word;
    logic                     req_err;
    logic                     idle;

    assign idle      = (state_q == S_IDLE);
    assign req_index = {2'b00, req_addr[ADDRESS_WIDTH-1:2]};
    assign req_err   = access_err(req_we, req_funct3, req_addr[1:0]);

    lsu_extend u_extend (
        .word   (mem_rd),
        .lane   (req_addr[1:0]),
        .funct3 (req_funct3),
        .result (load_ext)
    );

    // Only meaningful for legal SB/SH: funct3[0] separates halfword from byte.
    always_comb begin
        merge_word = mem_rd;
        if (req_funct3[0]) begin
            merge_word[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end else begin
            merge_word[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end
    end

    // NOTE: every signal gets its hold value first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        index_d = index_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    index_d = req_index;
                    if (req_err) begin
                        state_d = S_ERR_RSP;
                    end else if (!req_we) begin
                        rdata_d = load_ext;
                        state_d = S_LOAD_RSP;
                    end else if (req_funct3 == F3_W) begin
                        state_d = S_LOAD_RSP;
                    end else begin
                        merge_d = merge_word;
                        state_d = S_RMW_WR;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            merge_q <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            index_q <= index_d;
        end
    end

    // Word stores write straight through in the acceptance cycle.
    assign mem_we     = (idle && req_valid && req_we && !req_err && req_funct3 == F3_W)
                        || (state_q == S_RMW_WR);
    assign mem_a      = idle ? req_index : index_q;
    assign mem_wd     = (state_q == S_RMW_WR) ? merge_q : req_wdata;
    assign req_ready  = idle;
    assign resp_valid = !idle;
    assign resp_err   = (state_q == S_ERR_RSP);
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: directed cases with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int errors = 0;
    int checks = 0;

    load_store_unit #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    // 16-word RAM covering word indices 0x10000..0x1000F (bytes 0x40000..0x4003F).
    logic [31:0] ram [16];
    logic        do_preload;

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h8000_00F0 : (32'h1357_9BDF ^ (i * 32'h0101_0101));
    endfunction

    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (mem_we) begin
            ram[mem_a[3:0]] <= mem_wd;
        end
    end

    assign mem_rd = ram[mem_a[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one access outstanding, every response exactly
    // one cycle after acceptance, memory effect applied at acceptance.
    logic [31:0] model_mem [16];
    logic        mon_en;
    bit          busy;
    logic [31:0] held;
    bit          p_err, p_rmw;
    logic [31:0] p_idx, p_wd;
    int unsigned m_n, m_off, m_idx;
    logic [63:0] m_mask, m_word, m_val;
    bit          m_illegal;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            held = '0;
            if (do_preload) for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
        end else if (!mon_en) begin
            busy = 1'b0;
        end else begin
            check("req_ready", {31'b0, req_ready}, {31'b0, !busy});
            if (busy) begin
                check("resp_valid", {31'b0, resp_valid}, 32'd1);
                check("resp_err", {31'b0, resp_err}, {31'b0, p_err});
                check("resp_rdata", resp_rdata, held);
                check("mem_we_busy", {31'b0, mem_we}, {31'b0, p_rmw});
                check("mem_a_busy", mem_a, p_idx);
                if (p_rmw) check("mem_wd_rmw", mem_wd, p_wd);
            end else begin
                check("resp_valid_idle", {31'b0, resp_valid}, 32'd0);
                check("mem_a_idle", mem_a, req_addr >> 2);
                if (!req_valid) begin
                    check("mem_we_idle", {31'b0, mem_we}, 32'd0);
                end else begin
                    m_n       = (req_funct3[1:0] == 2'd0) ? 1 : (req_funct3[1:0] == 2'd1) ? 2 : 4;
                    m_off     = req_addr % 4;
                    m_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7)
                                || (req_we && req_funct3[2]);
                    p_err     = m_illegal || (m_off % m_n != 0);
                    p_idx     = req_addr / 4;
                    m_idx     = req_addr / 4 - 32'h1_0000;
                    p_rmw     = 1'b0;
                    m_mask    = (64'd1 << (8 * m_n)) - 64'd1;
                    m_word    = {32'h0, model_mem[m_idx]};
                    if (p_err) begin
                        check("mem_we_err", {31'b0, mem_we}, 32'd0);
                    end else if (!req_we) begin
                        m_val = (m_word >> (8 * m_off)) & m_mask;
                        if (!req_funct3[2] && m_n < 4 && m_val[8 * m_n - 1]) m_val = m_val | ~m_mask;
                        held = m_val[31:0];
                        check("mem_we_load", {31'b0, mem_we}, 32'd0);
                    end else begin
                        m_word = (m_word & ~(m_mask << (8 * m_off)))
                                 | (({32'h0, req_wdata} & m_mask) << (8 * m_off));
                        model_mem[m_idx] = m_word[31:0];
                        if (m_n == 4) begin
                            check("mem_we_sw", {31'b0, mem_we}, 32'd1);
                            check("mem_wd_sw", mem_wd, req_wdata);
                        end else begin
                            p_rmw = 1'b1;
                            p_wd  = m_word[31:0];
                            check("mem_we_sub_accept", {31'b0, mem_we}, 32'd0);
                        end
                    end
                end
            end
            busy = !busy && req_valid;
        end
    end

    // Called just after a rising edge; drives one request and returns just
    // after its acceptance edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int waits);
        waits = 0;
        while (!req_ready && waits < 10) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!req_ready) check("issue_ready_timeout", {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic xact(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rdata);
        int w;
        issue(we, f3, addr, wd, w);
        @(negedge clk);
        check({name, "_valid"}, {31'b0, resp_valid}, 32'd1);
        check({name, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({name, "_rdata"}, resp_rdata, exp_rdata);
        check({name, "_busy"}, {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check({name, "_ready_again"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n      = 1'b0;
        do_preload = 1'b1;
        mon_en     = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0004_0000;
        req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        do_preload = 1'b0;
        rst_n      = 1'b1;

        xact("lb",  1'b0, 3'b000, 32'h0004_0000, 32'h0, 1'b0, 32'hFFFF_FFF0);
        xact("lbu", 1'b0, 3'b100, 32'h0004_0000, 32'h0, 1'b0, 32'h0000_00F0);
        xact("lh",  1'b0, 3'b001, 32'h0004_0002, 32'h0, 1'b0, 32'hFFFF_8000);
        xact("sw0", 1'b1, 3'b010, 32'h0004_0000, 32'h1122_3344, 1'b0, 32'hFFFF_8000);
        check("sw0_ram", ram[0], 32'h1122_3344);
        xact("sb",  1'b1, 3'b000, 32'h0004_0001, 32'h0000_00AB, 1'b0, 32'hFFFF_8000);
        check("sb_ram", ram[0], 32'h1122_AB44);
        xact("lw_mis", 1'b0, 3'b010, 32'h0004_0002, 32'h0, 1'b1, 32'hFFFF_8000);
        xact("sh_mis", 1'b1, 3'b001, 32'h0004_0003, 32'h0000_5555, 1'b1, 32'hFFFF_8000);
        check("sh_mis_ram", ram[0], 32'h1122_AB44);
        xact("sw_b2b", 1'b1, 3'b010, 32'h0004_0004, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_8000);
        xact("lw_b2b", 1'b0, 3'b010, 32'h0004_0004, 32'h0, 1'b0, 32'hDEAD_BEEF);

        // Reset lands in the RMW write cycle of an SB: the write must not happen.
        mon_en = 1'b0;
        issue(1'b1, 3'b000, 32'h0004_0009, 32'h0000_0077, w);
        check("rmw_we_before_rst", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rmw_rst_valid", {31'b0, resp_valid}, 32'd0);
        check("rmw_rst_err", {31'b0, resp_err}, 32'd0);
        check("rmw_rst_rdata", resp_rdata, 32'h0);
        check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        check("rmw_rst_ram", ram[2], init_word(2));
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        issue(1'b0, 3'b010, 32'h0004_0008, 32'h0, w);
        check("post_rst_waits", w, 32'd0);
        @(negedge clk);
        check("post_rst_valid", {31'b0, resp_valid}, 32'd1);
        check("post_rst_rdata", resp_rdata, init_word(2));
        @(posedge clk); #1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_we     = $urandom_range(0, 1) == 1;
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = 32'h0004_0000 + $urandom_range(0, 63);
            req_wdata  = $urandom;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) check("final_ram", ram[i], model_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
